// File: rtl/seg7_scan_ctrl.sv
// Scan controller for a 4-digit common-anode 7-segment display.
// A frame posted over valid/ready is held pending and swapped in only at a frame boundary.
module seg7_scan_ctrl #(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [15:0] wr_data,
  input  logic [3:0]  wr_dp,
  input  logic [3:0]  wr_blank,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] blank_cnt_q, blank_cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      act_data_q, act_data_d;
  logic [3:0]       act_dp_q, act_dp_d;
  logic [3:0]       act_blank_q, act_blank_d;
  logic [15:0]      pend_data_q, pend_data_d;
  logic [3:0]       pend_dp_q, pend_dp_d;
  logic [3:0]       pend_blank_q, pend_blank_d;
  logic             pending_q, pending_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frame_done_q, frame_done_d;

  logic       tick;
  logic       boundary;
  logic       xfer;
  logic [3:0] nibble;
  logic [3:0] digit_sel;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b0000001;
      4'h1: hex7 = 7'b1001111;
      4'h2: hex7 = 7'b0010010;
      4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100;
      4'h5: hex7 = 7'b0100100;
      4'h6: hex7 = 7'b0100000;
      4'h7: hex7 = 7'b0001111;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0000100;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001;
      4'hD: hex7 = 7'b1000010;
      4'hE: hex7 = 7'b0110000;
      default: hex7 = 7'b0111000;
    endcase
  endfunction

  // One-hot digit select; the anode pattern is its inverse, so it can never have two lows.
  for (genvar gi = 0; gi < 4; gi++) begin : g_sel
    assign digit_sel[gi] = (idx_q == 2'(gi));
  end

  assign tick     = (cnt_q == CNT_MAX);
  assign boundary = tick && (idx_q == 2'd3);
  assign xfer     = wr_valid && !pending_q;
  assign nibble   = act_data_q[{idx_q, 2'b00} +: 4];

  always_comb begin
    cnt_d        = cnt_q + 1'b1;
    idx_d        = idx_q;
    blank_cnt_d  = blank_cnt_q;
    act_data_d   = act_data_q;
    act_dp_d     = act_dp_q;
    act_blank_d  = act_blank_q;
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    pending_d    = pending_q;
    frame_done_d = boundary;

    if (tick) begin
      cnt_d       = '0;
      idx_d       = idx_q + 2'd1;
      blank_cnt_d = BLANK_LD;
    end else if (blank_cnt_q != '0) begin
      blank_cnt_d = blank_cnt_q - 1'b1;
    end

    // Commit uses the pending flag from before this edge, so a same-cycle write waits a frame.
    if (boundary && pending_q) begin
      act_data_d  = pend_data_q;
      act_dp_d    = pend_dp_q;
      act_blank_d = pend_blank_q;
      pending_d   = 1'b0;
    end

    if (xfer) begin
      pend_data_d  = wr_data;
      pend_dp_d    = wr_dp;
      pend_blank_d = wr_blank;
      pending_d    = 1'b1;
    end
  end

  always_comb begin
    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    if (!tick && blank_cnt_q == '0 && !act_blank_q[idx_q]) begin
      an_d  = ~digit_sel;
      seg_d = hex7(nibble);
      dp_d  = ~act_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      blank_cnt_q  <= '0;
      act_data_q   <= 16'h0000;
      act_dp_q     <= 4'b0000;
      act_blank_q  <= 4'b1111;
      pend_data_q  <= 16'h0000;
      pend_dp_q    <= 4'b0000;
      pend_blank_q <= 4'b0000;
      pending_q    <= 1'b0;
      an_q         <= 4'b1111;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      blank_cnt_q  <= blank_cnt_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign wr_ready   = !pending_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a cycle-indexed reference model queues the expected
// outputs after every clock edge and a negedge monitor compares them against the DUT.
module tb_seg7_scan_ctrl;

  localparam int D = 8;
  localparam int B = 1;
  localparam int FRAME = 4 * D;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic [15:0] wr_data = 16'h0;
  logic [3:0]  wr_dp = 4'h0;
  logic [3:0]  wr_blank = 4'h0;
  logic        wr_ready;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  seg7_scan_ctrl #(.CLK_DIV(D), .BLANK_CYC(B)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_dp(wr_dp), .wr_blank(wr_blank),
    .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
    logic       rdy;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  logic [6:0] hex_tbl [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  // Reference state: k counts edges since reset release; the scan position follows from k alone.
  int          k;
  logic [15:0] m_data;
  logic [3:0]  m_dp, m_blank;
  bit          m_pend;
  logic [15:0] p_data;
  logic [3:0]  p_dp, p_blank;
  bit          last_xfer;

  task automatic step();
    exp_t e;
    int pos, slot, digit, bl;
    bit dark, bnd, xfer;
    logic [3:0] nib;
    @(posedge clk);
    if (rst) begin
      e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.fd = 1'b0; e.rdy = 1'b1;
      k = 0; m_data = 16'h0; m_dp = 4'h0; m_blank = 4'hF; m_pend = 0; last_xfer = 0;
    end else begin
      pos   = k % D;
      slot  = k / D;
      digit = slot % 4;
      bl    = (slot > 0 && pos < B) ? (B - pos) : 0;
      dark  = (pos == D - 1) || (bl != 0) || m_blank[digit];
      nib   = m_data[digit*4 +: 4];
      e.an  = dark ? 4'hF : ~(4'b0001 << digit);
      e.seg = dark ? 7'h7F : hex_tbl[nib];
      e.dp  = dark ? 1'b1 : ~m_dp[digit];
      bnd   = (pos == D - 1) && (digit == 3);
      e.fd  = bnd;
      xfer  = wr_valid && !m_pend;
      if (bnd && m_pend) begin
        m_data = p_data; m_dp = p_dp; m_blank = p_blank; m_pend = 0;
      end
      if (xfer) begin
        p_data = wr_data; p_dp = wr_dp; p_blank = wr_blank; m_pend = 1;
        $display("write k=%0d data=%h dp=%b blank=%b boundary=%0d", k, wr_data, wr_dp, wr_blank, bnd);
      end
      e.rdy = !m_pend;
      last_xfer = xfer;
      k++;
    end
    exp_q.push_back(e);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic write(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    int guard;
    guard = 0;
    wr_valid = 1'b1; wr_data = d; wr_dp = p; wr_blank = b;
    do begin
      step();
      guard++;
    end while (!last_xfer && guard < 200);
    wr_valid = 1'b0;
    if (!last_xfer) begin
      errors++;
      $display("FAIL write_timeout: got no transfer after %0d cycles, required one", guard);
    end
  endtask

  task automatic wait_commit();
    int guard;
    guard = 0;
    while (m_pend && guard < 200) begin
      step();
      guard++;
    end
    if (m_pend) begin
      errors++;
      $display("FAIL commit_timeout: got pending after %0d cycles, required commit", guard);
    end
  endtask

  task automatic chk(input string name, input logic [6:0] got, input logic [6:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b required %b at t=%0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("an", {3'b0, an}, {3'b0, e.an});
      chk("seg", seg, e.seg);
      chk("dp", {6'b0, dp}, {6'b0, e.dp});
      chk("frame_done", {6'b0, frame_done}, {6'b0, e.fd});
      chk("wr_ready", {6'b0, wr_ready}, {6'b0, e.rdy});
      checks++;
      if (!(an inside {4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111})) begin
        errors++;
        $display("FAIL an_onehot: got %b required all-off or one-hot-low", an);
      end
    end
  end

  initial begin
    // Reset, then a mid-scan reset with a frame pending: display must stay dark.
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(12);
    write(16'hABCD, 4'b1111, 4'b0000);
    idle(5);
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(FRAME + 8);

    // Basic content and decimal point on digit 2.
    write(16'h1234, 4'b0100, 4'b0000);
    wait_commit();
    idle(2 * FRAME);

    // Second request while busy must be ignored.
    write(16'h5678, 4'b0001, 4'b0000);
    wr_valid = 1'b1; wr_data = 16'h9999; wr_dp = 4'b1111; wr_blank = 4'b0000;
    idle(3);
    wr_valid = 1'b0;
    wait_commit();
    idle(FRAME);

    // Transfer landing exactly on the frame boundary.
    while ((k % FRAME) != FRAME - 1) step();
    write(16'hC0DE, 4'b1000, 4'b0000);
    idle(3 * FRAME);

    // Blank mask.
    write(16'hFFFF, 4'b0000, 4'b1010);
    wait_commit();
    idle(2 * FRAME);

    // Decode sweep on digit 0.
    for (int v = 0; v < 16; v++) begin
      write({16'($urandom_range(0, 4095)) << 4} | 16'(v), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)) & 4'b1110);
      wait_commit();
      idle(FRAME);
    end

    // Random back-to-back posts with random gaps.
    for (int i = 0; i < 10; i++) begin
      write(16'($urandom), 4'($urandom), 4'($urandom));
      idle($urandom_range(0, 40));
    end
    wait_commit();
    idle(FRAME + 4);

    repeat (2) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
